// File: rtl/disp_pkg.sv
// Shared constants and state encoding for the display channel arbiter.
package disp_pkg;
    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        MANUAL,
        IDLE,
        HOLD
    } arb_state_t;
endpackage

// File: rtl/disp_chan_arbiter_if.sv
// Control and status bundle between the arbiter and its driver.
interface disp_chan_arbiter_if;
    import disp_pkg::*;

    logic             EN;
    logic             auto_mode;
    logic [SEL_W-1:0] sw_test;
    logic [NCH-1:0]   upd_req;
    logic [SEL_W-1:0] test_sel;
    logic             grant_stb;
    logic             busy;
    logic [NCH-1:0]   pending;

    modport master (
        output EN, auto_mode, sw_test, upd_req,
        input  test_sel, grant_stb, busy, pending
    );

    modport slave (
        input  EN, auto_mode, sw_test, upd_req,
        output test_sel, grant_stb, busy, pending
    );
endinterface

// File: rtl/rr_pick8.sv
// Round-robin picker: first set request after 'last', wrapping, with 'last' itself checked last.
module rr_pick8
    import disp_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] win
);
    always_comb begin
        logic [SEL_W-1:0] idx;
        // NOTE: every output gets a default before the loop so no latch is inferred.
        any = 1'b0;
        win = last;
        idx = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = last + SEL_W'(i);
            if (!any && req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end
endmodule

// File: rtl/disp_chan_arbiter.sv
// Channel-select sequencer for the display multiplexer: manual passthrough or
// round-robin grants of pending update requests, each held for DWELL cycles.
module disp_chan_arbiter
    import disp_pkg::*;
#(
    parameter int DWELL   = 50_000_000,
    parameter int DWELL_W = 26
) (
    input logic                clk,
    input logic                rst,
    disp_chan_arbiter_if.slave bus
);
    arb_state_t       state_q, state_d;
    logic [NCH-1:0]   pending_q, pending_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] test_sel_q, test_sel_d;
    logic             grant_stb_q, grant_stb_d;
    logic             do_grant;
    logic [NCH-1:0]   clr_mask;
    logic             pick_any;
    logic [SEL_W-1:0] pick_win;

    rr_pick8 u_pick (
        .req  (pending_q),
        .last (last_q),
        .any  (pick_any),
        .win  (pick_win)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        test_sel_d  = test_sel_q;
        grant_stb_d = 1'b0;
        do_grant    = 1'b0;

        unique case (state_q)
            MANUAL: begin
                test_sel_d = bus.sw_test;
                if (bus.auto_mode) state_d = IDLE;
            end
            IDLE: begin
                if (!bus.auto_mode)          state_d  = MANUAL;
                else if (bus.EN && pick_any) do_grant = 1'b1;
            end
            HOLD: begin
                if (!bus.auto_mode) begin
                    state_d = MANUAL;
                    cnt_d   = '0;
                end else if (bus.EN) begin
                    if (cnt_q != '0) cnt_d    = cnt_q - DWELL_W'(1);
                    else if (pick_any) do_grant = 1'b1;
                    else               state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_grant) begin
            test_sel_d  = pick_win;
            last_d      = pick_win;
            cnt_d       = DWELL_W'(DWELL - 1);
            grant_stb_d = 1'b1;
            state_d     = HOLD;
        end

        // New requests are OR-ed in after the clear so a same-cycle request survives.
        clr_mask           = '0;
        clr_mask[pick_win] = do_grant;
        pending_d          = (pending_q & ~clr_mask) | bus.upd_req;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= bus.auto_mode ? IDLE : MANUAL;
            pending_q   <= '0;
            last_q      <= SEL_W'(NCH - 1);
            cnt_q       <= '0;
            test_sel_q  <= '0;
            grant_stb_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            test_sel_q  <= test_sel_d;
            grant_stb_q <= grant_stb_d;
        end
    end

    assign bus.test_sel  = test_sel_q;
    assign bus.grant_stb = grant_stb_q;
    assign bus.busy      = (state_q == HOLD);
    assign bus.pending   = pending_q;
endmodule

// File: tb/tb_disp_chan_arbiter.sv
// Directed bench for disp_chan_arbiter with DWELL=4; expected values worked out by hand.
module tb_disp_chan_arbiter;
    localparam int DWELL = 4;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    disp_chan_arbiter_if bus ();

    disp_chan_arbiter #(
        .DWELL   (DWELL),
        .DWELL_W (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] sel, input logic stb,
                              input logic bsy, input logic [7:0] pend);
        n_cmp++;
        assert (bus.test_sel === sel) else begin
            n_bad++;
            $error("FAIL %s.test_sel: observed %0h expected %0h", tag, bus.test_sel, sel);
        end
        n_cmp++;
        assert (bus.grant_stb === stb) else begin
            n_bad++;
            $error("FAIL %s.grant_stb: observed %0b expected %0b", tag, bus.grant_stb, stb);
        end
        n_cmp++;
        assert (bus.busy === bsy) else begin
            n_bad++;
            $error("FAIL %s.busy: observed %0b expected %0b", tag, bus.busy, bsy);
        end
        n_cmp++;
        assert (bus.pending === pend) else begin
            n_bad++;
            $error("FAIL %s.pending: observed %0h expected %0h", tag, bus.pending, pend);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.EN        = 1'b1;
        bus.auto_mode = 1'b1;
        bus.sw_test   = 3'd0;
        bus.upd_req   = 8'h00;
        tick();
        tick();
        expect_out("reset", 3'd0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out("idle_wait", 3'd0, 1'b0, 1'b0, 8'h00);
        end

        // Requests on ch2 and ch5 together: ch2 first, ch5 four cycles later.
        bus.upd_req = 8'h24;
        tick();
        expect_out("req24_capture", 3'd0, 1'b0, 1'b0, 8'h24);
        bus.upd_req = 8'h00;
        tick();
        expect_out("grant_ch2", 3'd2, 1'b1, 1'b1, 8'h20);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("hold_ch2", 3'd2, 1'b0, 1'b1, 8'h20);
        end
        tick();
        expect_out("grant_ch5", 3'd5, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("hold_ch5", 3'd5, 1'b0, 1'b1, 8'h00);
        end
        tick();
        expect_out("back_to_idle", 3'd5, 1'b0, 1'b0, 8'h00);

        // Move last to 6, then request ch7 and ch0: scan must wrap 7 -> 0.
        bus.upd_req = 8'h40;
        tick();
        bus.upd_req = 8'h00;
        tick();
        expect_out("grant_ch6", 3'd6, 1'b1, 1'b1, 8'h00);
        bus.upd_req = 8'h81;
        tick();
        expect_out("req81_capture", 3'd6, 1'b0, 1'b1, 8'h81);
        bus.upd_req = 8'h00;
        tick();
        tick();
        expect_out("hold_ch6_end", 3'd6, 1'b0, 1'b1, 8'h81);
        tick();
        expect_out("grant_ch7", 3'd7, 1'b1, 1'b1, 8'h01);
        tick();
        tick();
        tick();
        expect_out("hold_ch7_end", 3'd7, 1'b0, 1'b1, 8'h01);
        tick();
        expect_out("grant_ch0_wrap", 3'd0, 1'b1, 1'b1, 8'h00);
        tick();
        tick();
        tick();
        tick();
        expect_out("idle_after_wrap", 3'd0, 1'b0, 1'b0, 8'h00);

        // ch3 request held through its own grant edge: request beats the clear.
        bus.upd_req = 8'h08;
        tick();
        tick();
        expect_out("grant_ch3_keep", 3'd3, 1'b1, 1'b1, 8'h08);
        bus.upd_req = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("hold_ch3", 3'd3, 1'b0, 1'b1, 8'h08);
        end
        tick();
        expect_out("regrant_ch3", 3'd3, 1'b1, 1'b1, 8'h00);

        // Freeze at cnt=2 for 5 cycles, then expect the ch4 grant on the third enabled edge.
        bus.upd_req = 8'h10;
        tick();
        expect_out("req10_capture", 3'd3, 1'b0, 1'b1, 8'h10);
        bus.upd_req = 8'h00;
        bus.EN      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("frozen", 3'd3, 1'b0, 1'b1, 8'h10);
        end
        bus.EN = 1'b1;
        tick();
        expect_out("resume_cnt1", 3'd3, 1'b0, 1'b1, 8'h10);
        tick();
        expect_out("resume_cnt0", 3'd3, 1'b0, 1'b1, 8'h10);
        tick();
        expect_out("grant_ch4", 3'd4, 1'b1, 1'b1, 8'h00);

        // Drop to manual mid-hold with ch1 pending; pending must survive the round trip.
        bus.upd_req = 8'h02;
        tick();
        bus.upd_req   = 8'h00;
        bus.sw_test   = 3'd6;
        bus.auto_mode = 1'b0;
        tick();
        expect_out("enter_manual", 3'd4, 1'b0, 1'b0, 8'h02);
        tick();
        expect_out("manual_sel6", 3'd6, 1'b0, 1'b0, 8'h02);
        bus.sw_test = 3'd5;
        tick();
        expect_out("manual_sel5", 3'd5, 1'b0, 1'b0, 8'h02);
        bus.auto_mode = 1'b1;
        tick();
        expect_out("auto_reentry", 3'd5, 1'b0, 1'b0, 8'h02);
        tick();
        expect_out("grant_ch1_preserved", 3'd1, 1'b1, 1'b1, 8'h00);

        // Reset mid-hold with every request asserted: reset wins, last returns to 7.
        rst         = 1'b1;
        bus.upd_req = 8'hFF;
        tick();
        expect_out("reset_mid_hold", 3'd0, 1'b0, 1'b0, 8'h00);
        rst         = 1'b0;
        bus.upd_req = 8'h81;
        tick();
        bus.upd_req = 8'h00;
        tick();
        expect_out("post_reset_grant_ch0", 3'd0, 1'b1, 1'b1, 8'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/disp_chan_arbiter.md
# disp_chan_arbiter

Sequencer for the 8-channel 32-bit display multiplexer: produces the 3-bit channel select driving the multiplexer's `Test` input. In manual mode it forwards the switch-selected channel; in auto mode it tracks per-channel update requests and grants the display to pending channels in round-robin order. Each granted channel is held for a fixed dwell time. It sits between the CPU/peripheral data sources (which pulse update requests) and the display multiplexer / 7-segment scanner.

## Interface
- `DWELL`, default 50_000_000: clk cycles a granted channel is held in auto mode (≥2).
- `DWELL_W`, default 26: counter width; must satisfy 2^DWELL_W ≥ DWELL.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `EN`  in  1  arbitration/dwell enable; 0 freezes state machine and dwell counter.
- `auto_mode`  in  1  1 = auto arbitration, 0 = manual.
- `sw_test`  in  3  manual channel select.
- `upd_req`  in  8  per-channel update request, level-sampled each cycle.
- `test_sel`  out  3  channel select to the multiplexer `Test` input.
- `grant_stb`  out  1  one-cycle pulse on each auto-mode grant.
- `busy`  out  1  1 while in HOLD.
- `pending`  out  8  outstanding request flags.

## Operation
- Reset values: `test_sel`=0, `grant_stb`=0, `busy`=0, `pending`=0, `last`=7 (so the first search starts at ch0), dwell count 0, state MANUAL if `auto_mode`=0, else IDLE.
- Pending capture, every cycle, independent of EN and mode: `pending[i]` ← 1 when `upd_req[i]`=1.
  - A grant clears the winner's bit.
  - A request and a clear on the same bit in the same cycle leave it set (request wins).
- States: MANUAL, IDLE, HOLD.
- MANUAL: `test_sel` ← `sw_test` each cycle (ignores EN).
  - Exit to IDLE when `auto_mode`=1.
- IDLE, when EN=1 and `pending`≠0:
  - Winner = first set bit scanning `last`+1, `last`+2 … mod 8.
  - `test_sel` ← winner, `last` ← winner, clear `pending[winner]`.
  - Load `cnt` ← DWELL−1, pulse `grant_stb`, go to HOLD.
  - If `pending`=0, stay in IDLE; `test_sel` holds its last value.
- HOLD, when EN=1:
  - `cnt`≠0: decrement.
  - `cnt`=0 and `pending`≠0: regrant immediately, as in IDLE (back-to-back grants, no idle bubble).
  - `cnt`=0 and `pending`=0: go to IDLE.
- `auto_mode`=0 in IDLE or HOLD: go to MANUAL next edge and abort the hold. `pending` and `last` are retained.
- EN=0: IDLE/HOLD frozen (no grant, no decrement); `pending` still captures.
- Round-robin wrap: from `last`=7 the scan starts at 0.
  - Only `last` pending: that channel is regranted.

## Timing
- `upd_req[i]` high at edge k → `pending[i]`=1 after edge k.
- From IDLE with EN=1: grant at edge k+1, so `test_sel` and `grant_stb` are valid after k+1 (2-cycle latency).
- Each auto grant holds `test_sel` for exactly DWELL cycles of EN=1 before the next grant can change it.
- Manual-mode latency: 1 cycle from `sw_test` to `test_sel`.
- `rst` overrides all other inputs on the same edge.
- `rst` mid-HOLD returns to reset values at that edge.

## Structure
- Shared package `disp_pkg`:
  - `NCH`=8, `SEL_W`=3.
  - State enum `arb_state_t` {MANUAL, IDLE, HOLD}.
- Sub-module `rr_pick8` (combinational):
  - Inputs: `req[7:0]`, `last[2:0]`.
  - Outputs: `any`, `win[2:0]`.
  - Rotate-and-priority-encode.
- Top module: pending register, state register, dwell counter, output registers.

## Test plan
Bench uses DWELL=4.
- Reset with `auto_mode`=1, `upd_req`=0 → `test_sel`=0, `busy`=0, `pending`=0; stays IDLE for 10 cycles.
- Auto, EN=1: pulse `upd_req`=8'h24 for one cycle at edge k → grant ch2 at k+1 with `grant_stb`. Ch5 is granted exactly 4 cycles later, then IDLE after 4 more cycles with `test_sel`=5.
- Round-robin wrap: `last`=6, hold `upd_req`=8'h81 for one cycle → ch7 granted first, then ch0.
- Simultaneous event: during ch3 HOLD, `upd_req[3]`=1 on the cycle ch3 is granted → `pending[3]` stays 1; ch3 is regranted after the dwell.
- EN=0 for 5 cycles mid-HOLD (cnt=2) → `test_sel`, `cnt` and `busy` unchanged. On EN=1, the next grant occurs after exactly 3 more cycles (cnt 2→1→0, then regrant).
- Mode switch: drop `auto_mode` mid-HOLD with `sw_test`=6 → `test_sel`=6 within 2 cycles, `pending` preserved. Raise `auto_mode` → the preserved pending channel is granted 2 cycles later.
